// File: rtl/bus_arb_ctrl.sv
// Two-requester round-robin arbiter that sequences one command at a time onto
// the shared registered read/write bus and returns a completion pulse to the owner.
module bus_arb_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_0,
   input  logic              req_valid_1,
   output logic              req_ready_0,
   output logic              req_ready_1,
   input  logic              req_write_0,
   input  logic              req_write_1,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata_0,
   input  logic [DATA_W-1:0] req_wdata_1,
   output logic              rsp_valid_0,
   output logic              rsp_valid_1,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              read,
   output logic              write,
   output logic              enable,
   output logic [ADDR_W-1:0] raddr,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_t;

   state_t            state;
   logic              last_grant;
   logic              owner;
   logic              cur_write;
   logic [3:0]        lat_cnt;

   logic              accept;
   logic              win1;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
   // Ready is gated by rst_n so it drops in the same cycle reset is asserted.
   always_comb begin
      win1        = req_valid_1 & (~req_valid_0 | ~last_grant);
      accept      = rst_n & (state == IDLE) & (req_valid_0 | req_valid_1);
      req_ready_0 = accept & ~win1;
      req_ready_1 = accept & win1;
      sel_write   = win1 ? req_write_1 : req_write_0;
      sel_addr    = win1 ? req_addr_1  : req_addr_0;
      sel_wdata   = win1 ? req_wdata_1 : req_wdata_0;
   end

   // Bus command registers double as the latched request: they are loaded at
   // acceptance, shown for the single ISSUE cycle, and cleared afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         cur_write   <= 1'b0;
         lat_cnt     <= '0;
         enable      <= 1'b0;
         read        <= 1'b0;
         write       <= 1'b0;
         raddr       <= '0;
         waddr       <= '0;
         wdata       <= '0;
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         enable      <= 1'b0;
         read        <= 1'b0;
         write       <= 1'b0;
         raddr       <= '0;
         waddr       <= '0;
         wdata       <= '0;
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= win1;
                  last_grant <= win1;
                  cur_write  <= sel_write;
                  enable     <= 1'b1;
                  if (sel_write) begin
                     write <= 1'b1;
                     waddr <= sel_addr;
                     wdata <= sel_wdata;
                  end else begin
                     read  <= 1'b1;
                     raddr <= sel_addr;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (cur_write) begin
                  rsp_valid_0 <= ~owner;
                  rsp_valid_1 <= owner;
                  state       <= RESP;
               end else begin
                  lat_cnt <= 4'(RD_LATENCY - 1);
                  state   <= RWAIT;
               end
            end
            RWAIT: begin
               if (lat_cnt == 4'd0) begin
                  rsp_rdata   <= rdata;
                  rsp_valid_0 <= ~owner;
                  rsp_valid_1 <= owner;
                  state       <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// Bench for bus_arb_ctrl: two instances (read latency 1 and 4) checked every cycle
// against a transaction-timeline model, plus literal timing/order expectations.
module tb_bus_arb_ctrl;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] ret;
      int         gap;
      bit         drop;
   } txn_t;

   typedef struct {
      int         c;
      int         r;
      logic [7:0] d;
   } ev_t;

   logic clk;
   int   cyc;
   int   checks;
   int   errors;

   logic       rstn [2];
   logic       v0 [2], v1 [2], w0 [2], w1 [2];
   logic [7:0] a0 [2], a1 [2], d0 [2], d1 [2], rdat [2];
   logic       o_rdy0 [2], o_rdy1 [2], o_rv0 [2], o_rv1 [2];
   logic       o_rd [2], o_wr [2], o_en [2];
   logic [7:0] o_rrd [2], o_ra [2], o_wa [2], o_wd [2];

   // requester queues, index = dut*2 + requester
   txn_t q [4][$];
   bit   loaded [4];
   bit   presented [4];
   int   gapc [4];

   ev_t  acc_log [2][$];
   ev_t  rsp_log [2][$];

   // transaction-level model state per DUT
   bit         mbusy [2];
   int         ma [2], mr [2], mown [2], mlast [2];
   bit         mwr [2];
   logic [7:0] maddr [2], mdat [2], mret [2], mrrd [2];

   bus_arb_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rstn[0]),
      .req_valid_0(v0[0]), .req_valid_1(v1[0]),
      .req_ready_0(o_rdy0[0]), .req_ready_1(o_rdy1[0]),
      .req_write_0(w0[0]), .req_write_1(w1[0]),
      .req_addr_0(a0[0]), .req_addr_1(a1[0]),
      .req_wdata_0(d0[0]), .req_wdata_1(d1[0]),
      .rsp_valid_0(o_rv0[0]), .rsp_valid_1(o_rv1[0]), .rsp_rdata(o_rrd[0]),
      .read(o_rd[0]), .write(o_wr[0]), .enable(o_en[0]),
      .raddr(o_ra[0]), .waddr(o_wa[0]), .wdata(o_wd[0]), .rdata(rdat[0])
   );

   bus_arb_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(4)) u_lat4 (
      .clk(clk), .rst_n(rstn[1]),
      .req_valid_0(v0[1]), .req_valid_1(v1[1]),
      .req_ready_0(o_rdy0[1]), .req_ready_1(o_rdy1[1]),
      .req_write_0(w0[1]), .req_write_1(w1[1]),
      .req_addr_0(a0[1]), .req_addr_1(a1[1]),
      .req_wdata_0(d0[1]), .req_wdata_1(d1[1]),
      .rsp_valid_0(o_rv0[1]), .rsp_valid_1(o_rv1[1]), .rsp_rdata(o_rrd[1]),
      .read(o_rd[1]), .write(o_wr[1]), .enable(o_en[1]),
      .raddr(o_ra[1]), .waddr(o_wa[1]), .wdata(o_wd[1]), .rdata(rdat[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endfunction

   function automatic ev_t acc_at(int k, int i);
      if (i < acc_log[k].size()) return acc_log[k][i];
      return '{-1000, -1, 8'h00};
   endfunction

   function automatic ev_t rsp_at(int k, int i);
      if (i < rsp_log[k].size()) return rsp_log[k][i];
      return '{-1000, -1, 8'h00};
   endfunction

   task automatic push(input int i, input bit wr, input logic [7:0] addr,
                       input logic [7:0] data, input logic [7:0] ret,
                       input int gap, input bit drop);
      q[i].push_back('{wr, addr, data, ret, gap, drop});
   endtask

   task automatic set_req(input int k, input int r, input logic v, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
      if (r == 0) begin
         v0[k] = v; w0[k] = w; a0[k] = a; d0[k] = d;
      end else begin
         v1[k] = v; w1[k] = w; a1[k] = a; d1[k] = d;
      end
   endtask

   task automatic drive_agent(input int i);
      int k = i / 2;
      int r = i % 2;
      if (q[i].size() > 0 && q[i][0].drop && presented[i]) begin
         void'(q[i].pop_front());
         loaded[i]    = 0;
         presented[i] = 0;
      end
      set_req(k, r, 1'b0, 1'b0, 8'h00, 8'h00);
      if (q[i].size() > 0) begin
         if (!loaded[i]) begin
            gapc[i]   = q[i][0].gap;
            loaded[i] = 1;
         end
         if (gapc[i] > 0) gapc[i]--;
         else begin
            set_req(k, r, 1'b1, q[i][0].wr, q[i][0].addr, q[i][0].data);
            presented[i] = 1;
         end
      end
   endtask

   // One cycle of the model: expected outputs come from where the cycle sits
   // relative to the accepted transaction's timeline (accept, +1 command, response).
   task automatic step(input int k);
      int         c      = cyc;
      int         lat    = (k == 1) ? 4 : 1;
      int         win    = -1;
      logic       e_rdy0 = 0, e_rdy1 = 0, e_rv0 = 0, e_rv1 = 0;
      logic       e_en = 0, e_rd = 0, e_wr = 0;
      logic [7:0] e_ra = '0, e_wa = '0, e_wd = '0;
      if (!rstn[k]) begin
         mbusy[k] = 0;
         mlast[k] = 1;
         mrrd[k]  = '0;
      end else begin
         if (mbusy[k] && c > mr[k]) mbusy[k] = 0;
         if (mbusy[k]) begin
            if (c == ma[k] + 1) begin
               e_en = 1;
               if (mwr[k]) begin
                  e_wr = 1; e_wa = maddr[k]; e_wd = mdat[k];
               end else begin
                  e_rd = 1; e_ra = maddr[k];
               end
            end
            if (c == mr[k]) begin
               if (mown[k] == 0) e_rv0 = 1; else e_rv1 = 1;
               if (!mwr[k]) mrrd[k] = mret[k];
            end
         end else if (v0[k] || v1[k]) begin
            if (v0[k] && v1[k]) win = (mlast[k] == 0) ? 1 : 0;
            else win = v0[k] ? 0 : 1;
            if (win == 0) e_rdy0 = 1; else e_rdy1 = 1;
         end
      end
      chk("req_ready_0", k, o_rdy0[k], e_rdy0);
      chk("req_ready_1", k, o_rdy1[k], e_rdy1);
      chk("rsp_valid_0", k, o_rv0[k], e_rv0);
      chk("rsp_valid_1", k, o_rv1[k], e_rv1);
      chk("rsp_rdata", k, o_rrd[k], mrrd[k]);
      chk("enable", k, o_en[k], e_en);
      chk("read", k, o_rd[k], e_rd);
      chk("write", k, o_wr[k], e_wr);
      chk("raddr", k, o_ra[k], e_ra);
      chk("waddr", k, o_wa[k], e_wa);
      chk("wdata", k, o_wd[k], e_wd);
      if (o_rdy0[k]) acc_log[k].push_back('{c, 0, 8'h00});
      if (o_rdy1[k]) acc_log[k].push_back('{c, 1, 8'h00});
      if (o_rv0[k])  rsp_log[k].push_back('{c, 0, o_rrd[k]});
      if (o_rv1[k])  rsp_log[k].push_back('{c, 1, o_rrd[k]});
      if (win >= 0) begin
         mbusy[k] = 1;
         ma[k]    = c;
         mown[k]  = win;
         mlast[k] = win;
         mwr[k]   = (win == 1) ? w1[k] : w0[k];
         maddr[k] = (win == 1) ? a1[k] : a0[k];
         mdat[k]  = (win == 1) ? d1[k] : d0[k];
         mret[k]  = q[k*2 + win][0].ret;
         mr[k]    = mwr[k] ? c + 2 : c + 2 + lat;
         void'(q[k*2 + win].pop_front());
         loaded[k*2 + win]    = 0;
         presented[k*2 + win] = 0;
      end
   endtask

   // Drive on the falling edge; read data is valid only in the model's sampling cycle.
   always begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) drive_agent(i);
      for (int k = 0; k < 2; k++) begin
         if (mbusy[k] && !mwr[k] && cyc == ma[k] + 1 + ((k == 1) ? 4 : 1))
            rdat[k] = mret[k];
         else if (mbusy[k])
            rdat[k] = mret[k] ^ 8'hA5;
         else
            rdat[k] = 8'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) step(k);
   end

   task automatic wait_idle(input int k);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (q[2*k].size() == 0 && q[2*k+1].size() == 0 && !mbusy[k]) return;
      end
      chk("idle_timeout", k, 32'd1, 32'd0);
   endtask

   initial begin
      cyc    = 0;
      checks = 0;
      errors = 0;
      for (int k = 0; k < 2; k++) begin
         set_req(k, 0, 1'b0, 1'b0, 8'h00, 8'h00);
         set_req(k, 1, 1'b0, 1'b0, 8'h00, 8'h00);
         rdat[k] = '0;
         mbusy[k] = 0; mlast[k] = 1; mrrd[k] = '0;
         rstn[k] = 1'b1;
      end
      #1;
      rstn[0] = 1'b0;
      rstn[1] = 1'b0;
      repeat (3) @(negedge clk);
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      #2;

      // single write, latency-1 instance
      push(0, 1, 8'h10, 8'hA5, 8'h00, 0, 0);
      wait_idle(0);
      chk("wr_owner", 0, acc_at(0, 0).r, 0);
      chk("wr_rsp_owner", 0, rsp_at(0, 0).r, 0);
      chk("wr_rsp_delay", 0, rsp_at(0, 0).c - acc_at(0, 0).c, 2);

      // single read, latency 1
      push(1, 0, 8'h20, 8'h00, 8'h3C, 0, 0);
      wait_idle(0);
      chk("rd1_owner", 0, rsp_at(0, 1).r, 1);
      chk("rd1_data", 0, rsp_at(0, 1).d, 8'h3C);
      chk("rd1_delay", 0, rsp_at(0, 1).c - acc_at(0, 1).c, 3);

      // contention: both continuously valid
      for (int i = 0; i < 3; i++) begin
         push(0, 1, 8'(8'h30 + i), 8'(8'h70 + i), 8'h00, 0, 0);
         push(1, 0, 8'(8'h40 + i), 8'h00, 8'(8'hC0 + i), 0, 0);
      end
      wait_idle(0);
      for (int i = 0; i < 6; i++) begin
         chk("grant_order", 0, acc_at(0, 2 + i).r, i % 2);
         chk("rsp_owner", 0, rsp_at(0, 2 + i).r, i % 2);
      end
      chk("wr_to_next_grant", 0, acc_at(0, 3).c - acc_at(0, 2).c, 3);
      chk("rd1_to_next_grant", 0, acc_at(0, 4).c - acc_at(0, 3).c, 4);

      // latency 4, single requester back to back, all-ones address and data
      push(2, 0, 8'hFF, 8'h00, 8'hFF, 0, 0);
      push(2, 1, 8'hFF, 8'hFF, 8'h00, 0, 0);
      push(2, 0, 8'h00, 8'h00, 8'h5A, 0, 0);
      wait_idle(1);
      chk("rd4_delay", 1, rsp_at(1, 0).c - acc_at(1, 0).c, 6);
      chk("rd4_data", 1, rsp_at(1, 0).d, 8'hFF);
      chk("rd4_to_next_grant", 1, acc_at(1, 1).c - acc_at(1, 0).c, 7);
      chk("wr_to_next_grant4", 1, acc_at(1, 2).c - acc_at(1, 1).c, 3);
      chk("rd4_data2", 1, rsp_at(1, 2).d, 8'h5A);

      // valid dropped before acceptance: no transaction
      push(2, 0, 8'h40, 8'h00, 8'h11, 0, 0);
      push(3, 1, 8'h41, 8'h41, 8'h00, 2, 1);
      wait_idle(1);
      chk("drop_acc_count", 1, acc_log[1].size(), 4);
      chk("drop_rsp_count", 1, rsp_log[1].size(), 4);

      // reset in the middle of a latency-4 read
      push(2, 0, 8'h50, 8'h00, 8'h22, 0, 0);
      for (int i = 0; i < 50 && acc_log[1].size() < 5; i++) begin
         @(negedge clk);
         #2;
      end
      chk("rst_rd_accepted", 1, acc_log[1].size(), 5);
      repeat (2) @(negedge clk);
      rstn[1] = 1'b0;
      repeat (2) @(negedge clk);
      rstn[1] = 1'b1;
      #2;
      push(3, 1, 8'h61, 8'h61, 8'h00, 0, 0);
      push(2, 1, 8'h60, 8'h60, 8'h00, 0, 0);
      wait_idle(1);
      chk("post_rst_first_grant", 1, acc_at(1, 5).r, 0);
      chk("post_rst_second_grant", 1, acc_at(1, 6).r, 1);
      chk("post_rst_rsp_count", 1, rsp_log[1].size(), 6);
      chk("post_rst_rsp_owner", 1, rsp_at(1, 4).r, 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
